// File: rtl/mmio_timer_core_pkg.sv
// Shared register map, control/status bit positions and CTRL layout for mmio_timer_core.
package mmio_timer_pkg;

    localparam logic [4:0] REG_CTRL     = 5'd0;
    localparam logic [4:0] REG_PRESCALE = 5'd1;
    localparam logic [4:0] REG_COUNT_LO = 5'd2;
    localparam logic [4:0] REG_COUNT_HI = 5'd3;
    localparam logic [4:0] REG_CMP_LO   = 5'd4;
    localparam logic [4:0] REG_CMP_HI   = 5'd5;
    localparam logic [4:0] REG_STATUS   = 5'd6;
    localparam logic [4:0] REG_CAP_LO   = 5'd7;
    localparam logic [4:0] REG_CAP_HI   = 5'd8;

    localparam int CTRL_GO       = 0;
    localparam int CTRL_CLR      = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_AUTO_RLD = 3;

    localparam int STAT_FLAG = 0;
    localparam int STAT_GO   = 1;
    localparam int STAT_CAPV = 2;

    typedef struct packed {
        logic auto_rld;
        logic irq_en;
        logic go;
    } ctrl_t;

    // The clear bit is a pulse and is never stored, so it always reads back 0.
    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w                = '0;
        w[CTRL_GO]       = c.go;
        w[CTRL_IRQ_EN]   = c.irq_en;
        w[CTRL_AUTO_RLD] = c.auto_rld;
        return w;
    endfunction

endpackage

// File: rtl/mmio_timer_core_if.sv
// Slot-side bus of the memory-mapped IO controller as seen by one IO core.
interface mmio_timer_core_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/mmio_timer_core_prescaler.sv
// Programmable tick divider: one tick every (div+1) enabled clocks.
module mmio_timer_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             restart,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q;
        if (restart || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_timer_core.sv
// Prescaled up-counter with compare/auto-reload, sticky match flag and level irq.
// Optional input capture is built when MMIO_TIMER_CAPTURE_EN is defined.
module mmio_timer_core
    import mmio_timer_pkg::*;
#(
    parameter int CNT_W = 48,
    parameter int PRE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    mmio_timer_core_if.slave    bus,
    input  logic                capture_in,
    output logic                irq
);

    localparam int HI_W = CNT_W - 32;

    ctrl_t            ctrl_q, ctrl_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [HI_W-1:0]  hi_shadow_q, hi_shadow_d;
    logic             flag_q, flag_d;
    logic             irq_q, irq_d;

    logic wr, rd, wr_ctrl, wr_status, clr, tick, match;

    assign wr        = bus.cs && bus.write;
    assign rd        = bus.cs && bus.read;
    assign wr_ctrl   = wr && (bus.addr == REG_CTRL);
    assign wr_status = wr && (bus.addr == REG_STATUS);
    assign clr       = wr_ctrl && bus.wr_data[CTRL_CLR];
    assign match     = tick && !clr && (count_q == cmp_q);
    assign irq       = irq_q;

    mmio_timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (ctrl_q.go),
        .restart (clr || (wr && (bus.addr == REG_PRESCALE))),
        .div     (prescale_q),
        .tick    (tick)
    );

    always_comb begin
        ctrl_d      = ctrl_q;
        prescale_d  = prescale_q;
        cmp_d       = cmp_q;
        count_d     = count_q;
        hi_shadow_d = hi_shadow_q;
        irq_d       = flag_q && ctrl_q.irq_en;

        if (wr_ctrl) begin
            ctrl_d.go       = bus.wr_data[CTRL_GO];
            ctrl_d.irq_en   = bus.wr_data[CTRL_IRQ_EN];
            ctrl_d.auto_rld = bus.wr_data[CTRL_AUTO_RLD];
        end
        if (wr && (bus.addr == REG_PRESCALE)) prescale_d = bus.wr_data[PRE_W-1:0];
        if (wr && (bus.addr == REG_CMP_LO))   cmp_d[31:0] = bus.wr_data;
        if (wr && (bus.addr == REG_CMP_HI))   cmp_d[CNT_W-1:32] = bus.wr_data[HI_W-1:0];
        if (rd && (bus.addr == REG_COUNT_LO)) hi_shadow_d = count_q[CNT_W-1:32];

        // Clear wins over a same-cycle tick; the natural wrap past all-ones raises no flag.
        if (clr) begin
            count_d = '0;
        end else if (match && ctrl_q.auto_rld) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + CNT_W'(1);
        end

        flag_d = match || (flag_q && !(wr_status && bus.wr_data[STAT_FLAG]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= '0;
            prescale_q  <= '0;
            cmp_q       <= '1;
            count_q     <= '0;
            hi_shadow_q <= '0;
            flag_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            prescale_q  <= prescale_d;
            cmp_q       <= cmp_d;
            count_q     <= count_d;
            hi_shadow_q <= hi_shadow_d;
            flag_q      <= flag_d;
            irq_q       <= irq_d;
        end
    end

`ifdef MMIO_TIMER_CAPTURE_EN
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cap_q;
    logic             capv_q;
    logic             cap_edge;

    assign cap_edge = sync_q[1] && !sync_q[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cap_q  <= '0;
            capv_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], capture_in};
            if (cap_edge) cap_q <= count_q;
            capv_q <= cap_edge || (capv_q && !(wr_status && bus.wr_data[STAT_CAPV]));
        end
    end
`else
    logic unused_capture;
    assign unused_capture = capture_in;
`endif

    always_comb begin
        bus.rd_data = '0;
        case (bus.addr)
            REG_CTRL:     bus.rd_data = ctrl_word(ctrl_q);
            REG_PRESCALE: bus.rd_data = 32'(prescale_q);
            REG_COUNT_LO: bus.rd_data = count_q[31:0];
            REG_COUNT_HI: bus.rd_data = 32'(hi_shadow_q);
            REG_CMP_LO:   bus.rd_data = cmp_q[31:0];
            REG_CMP_HI:   bus.rd_data = 32'(cmp_q[CNT_W-1:32]);
            REG_STATUS: begin
                bus.rd_data[STAT_FLAG] = flag_q;
                bus.rd_data[STAT_GO]   = ctrl_q.go;
`ifdef MMIO_TIMER_CAPTURE_EN
                bus.rd_data[STAT_CAPV] = capv_q;
`endif
            end
`ifdef MMIO_TIMER_CAPTURE_EN
            REG_CAP_LO:   bus.rd_data = cap_q[31:0];
            REG_CAP_HI:   bus.rd_data = 32'(cap_q[CNT_W-1:32]);
`endif
            default:      bus.rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_timer_core.sv
// Scoreboard bench for mmio_timer_core; read expectations are queued at drive time
// and checked on the following falling edge.
module tb_mmio_timer_core;
    import mmio_timer_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic capture_in = 1'b0;
    logic irq;

    mmio_timer_core_if bus();

    mmio_timer_core #(.CNT_W(48), .PRE_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .capture_in (capture_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } expT;

    expT expQ[$];
    expT monE;
    int  total = 0;
    int  bad = 0;
    logic [31:0] capLoExp;
    logic [31:0] statCapExp;
    logic [31:0] seqExp[8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // One bus cycle; for reads d is the expected data and goes onto the scoreboard.
    task automatic applyStimulus(input bit doWrite, input logic [4:0] a, input logic [31:0] d, input string tag);
        bus.cs   = 1'b1;
        bus.addr = a;
        if (doWrite) begin
            bus.write   = 1'b1;
            bus.wr_data = d;
        end else begin
            bus.read = 1'b1;
            expQ.push_back('{tag, d});
        end
        @(posedge clk);
        #1;
        bus.cs    = 1'b0;
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d, "wr");
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string tag);
        applyStimulus(1'b0, a, e, tag);
    endtask

    always @(negedge clk) begin
        if (bus.cs && bus.read) begin
            if (expQ.size() == 0) begin
                checkOutput("queue_underflow", 32'd1, 32'd0);
            end else begin
                monE = expQ.pop_front();
                checkOutput(monE.tag, bus.rd_data, monE.exp);
            end
        end
    end

    initial begin
        bus.cs = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.addr = '0;
        bus.wr_data = '0;
`ifdef MMIO_TIMER_CAPTURE_EN
        capLoExp = 32'd100;
        statCapExp = 32'h5;
`else
        capLoExp = 32'd0;
        statCapExp = 32'h1;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] reset values");
        rd(REG_CTRL,     32'h0,         "rst_ctrl");
        rd(REG_PRESCALE, 32'h0,         "rst_prescale");
        rd(REG_COUNT_LO, 32'h0,         "rst_count_lo");
        rd(REG_COUNT_HI, 32'h0,         "rst_count_hi");
        rd(REG_CMP_LO,   32'hFFFF_FFFF, "rst_cmp_lo");
        rd(REG_CMP_HI,   32'h0000_FFFF, "rst_cmp_hi");
        rd(REG_STATUS,   32'h0,         "rst_status");
        rd(REG_CAP_LO,   32'h0,         "rst_cap_lo");
        rd(REG_CAP_HI,   32'h0,         "rst_cap_hi");
        checkOutput("rst_irq", 32'(irq), 32'd0);

        $display("[TB] prescaled counting and freeze");
        wr(REG_PRESCALE, 32'd3);
        wr(REG_CTRL, 32'h1);
        repeat (40) @(posedge clk);
        #1;
        rd(REG_COUNT_LO, 32'd10, "pre3_count");
        wr(REG_CTRL, 32'h0);
        repeat (20) @(posedge clk);
        #1;
        rd(REG_COUNT_LO, 32'd10, "frozen_count");
        rd(REG_PRESCALE, 32'd3,  "prescale_rb");
        rd(REG_COUNT_HI, 32'd0,  "shadow_zero");

        $display("[TB] reset mid-count");
        wr(REG_CTRL, 32'h5);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        rd(REG_COUNT_LO, 32'd0,         "midrst_count");
        rd(REG_CTRL,     32'd0,         "midrst_ctrl");
        rd(REG_CMP_LO,   32'hFFFF_FFFF, "midrst_cmp");

        $display("[TB] compare, auto-reload, irq");
        wr(REG_PRESCALE, 32'd0);
        wr(REG_CMP_LO, 32'd5);
        wr(REG_CMP_HI, 32'd0);
        wr(REG_CTRL, 32'hD);
        for (int i = 0; i < 8; i++) begin
            rd(REG_COUNT_LO, seqExp[i], "reload_seq");
            if (i == 5) checkOutput("irq_lag", 32'(irq), 32'd0);
            if (i == 6) checkOutput("irq_rise", 32'(irq), 32'd1);
        end
        rd(REG_STATUS, 32'h3, "status_match");
        wr(REG_STATUS, 32'h1);
        checkOutput("irq_hold", 32'(irq), 32'd1);
        wr(REG_CTRL, 32'h0);
        checkOutput("irq_drop", 32'(irq), 32'd0);
        rd(REG_STATUS, 32'h0, "status_cleared");

        $display("[TB] shadowed high word");
        force dut.count_q = 48'h0000_FFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.count_q;
        rd(REG_COUNT_LO, 32'hFFFF_FFFF, "lo_all_ones");
        wr(REG_CTRL, 32'h1);
        wr(REG_CTRL, 32'h0);
        rd(REG_COUNT_HI, 32'd0, "hi_shadow_old");
        rd(REG_COUNT_LO, 32'd0, "lo_after_carry");
        rd(REG_COUNT_HI, 32'd1, "hi_shadow_new");

        $display("[TB] clear priority and W1C race");
        wr(REG_CTRL, 32'h1);
        wr(REG_CTRL, 32'h3);
        rd(REG_COUNT_LO, 32'd0, "clr_beats_tick");
        wr(REG_CMP_LO, 32'd4);
        repeat (2) @(posedge clk);
        #1;
        wr(REG_STATUS, 32'h1);
        wr(REG_CTRL, 32'h0);
        rd(REG_STATUS, 32'h1, "set_beats_w1c");
        wr(REG_STATUS, 32'h1);
        rd(REG_STATUS, 32'h0, "w1c_flag");
        wr(5'd9, 32'hFFFF_FFFF);
        rd(5'd9,  32'h0, "unmapped_9");
        rd(5'd31, 32'h0, "unmapped_31");

        $display("[TB] capture");
        wr(REG_CTRL, 32'h3);
        repeat (98) @(posedge clk);
        #1 capture_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 capture_in = 1'b0;
        wr(REG_CTRL, 32'h0);
        rd(REG_CAP_LO, capLoExp,   "cap_lo");
        rd(REG_CAP_HI, 32'd0,      "cap_hi");
        rd(REG_STATUS, statCapExp, "status_cap");
        wr(REG_STATUS, 32'h4);
        rd(REG_STATUS, 32'h1,      "capv_w1c");

        @(posedge clk);
        #1;
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
